// File: rtl/tcp_tx_sender.sv
// User-side TCP transmit engine: splits a send command into packets, issues
// tx_meta per packet, waits for tx_stat, then streams the payload with tlast/tkeep.
module tcp_tx_sender #(
  parameter int PKT_SIZE     = 4096,
  parameter int RETRY_CYCLES = 256,
  parameter int MAX_RETRY    = 15
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         s_cmd_valid,
  output logic         s_cmd_ready,
  input  logic [31:0]  s_cmd_data,
  output logic         m_tcp_tx_meta_valid,
  input  logic         m_tcp_tx_meta_ready,
  output logic [31:0]  m_tcp_tx_meta_data,
  input  logic         s_tcp_tx_stat_valid,
  output logic         s_tcp_tx_stat_ready,
  input  logic [63:0]  s_tcp_tx_stat_data,
  input  logic         s_axis_data_tvalid,
  output logic         s_axis_data_tready,
  input  logic [511:0] s_axis_data_tdata,
  output logic         m_axis_tcp_tx_tvalid,
  input  logic         m_axis_tcp_tx_tready,
  output logic [511:0] m_axis_tcp_tx_tdata,
  output logic [63:0]  m_axis_tcp_tx_tkeep,
  output logic         m_axis_tcp_tx_tlast,
  output logic         m_cpl_valid,
  input  logic         m_cpl_ready,
  output logic [32:0]  m_cpl_data
);

  // retries must be able to hold MAX_RETRY+1 so the abort test cannot wrap
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int CW = $clog2(RETRY_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_META, S_STAT, S_DATA, S_BACKOFF, S_DRAIN, S_CPL
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_sid;
  logic [15:0]     r_rem;
  logic [15:0]     r_sent;
  logic [15:0]     r_chunk;
  logic [15:0]     r_beats;
  logic [15:0]     r_beatCnt;
  logic [RW-1:0]   r_retries;
  logic [CW-1:0]   r_backoffCnt;
  logic            r_abort;

  logic [15:0]     w_chunk;
  logic [15:0]     w_chunkBeats;
  logic [15:0]     w_remBeats;
  logic            w_lastBeat;
  logic [63:0]     w_lastKeep;
  logic            w_statErr;
  logic [RW-1:0]   w_retryNext;
  logic            w_unused;

  assign w_chunk      = (r_rem > 16'(PKT_SIZE)) ? 16'(PKT_SIZE) : r_rem;
  assign w_chunkBeats = 16'((32'(r_chunk) + 32'd63) >> 6);
  assign w_remBeats   = 16'((32'(r_rem) + 32'd63) >> 6);
  assign w_lastBeat   = (r_beatCnt == r_beats - 16'd1);
  assign w_lastKeep   = (r_chunk[5:0] == 6'd0) ? '1 : ((64'd1 << r_chunk[5:0]) - 64'd1);
  assign w_statErr    = (s_tcp_tx_stat_data[63:62] != 2'd0);
  assign w_retryNext  = r_retries + RW'(1);
  assign w_unused     = ^s_tcp_tx_stat_data[61:0];

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    s_cmd_ready          = 1'b0;
    m_tcp_tx_meta_valid  = 1'b0;
    m_tcp_tx_meta_data   = '0;
    s_tcp_tx_stat_ready  = 1'b0;
    s_axis_data_tready   = 1'b0;
    m_axis_tcp_tx_tvalid = 1'b0;
    m_axis_tcp_tx_tdata  = '0;
    m_axis_tcp_tx_tkeep  = '0;
    m_axis_tcp_tx_tlast  = 1'b0;
    m_cpl_valid          = 1'b0;
    m_cpl_data           = '0;
    case (r_state)
      S_IDLE: begin
        s_cmd_ready = 1'b1;
        if (s_cmd_valid) w_next = S_META;
      end
      S_META: begin
        m_tcp_tx_meta_valid = 1'b1;
        m_tcp_tx_meta_data  = {w_chunk, r_sid};
        if (m_tcp_tx_meta_ready) w_next = S_STAT;
      end
      S_STAT: begin
        s_tcp_tx_stat_ready = 1'b1;
        if (s_tcp_tx_stat_valid) begin
          if (!w_statErr)                      w_next = S_DATA;
          else if (w_retryNext > RW'(MAX_RETRY)) w_next = S_DRAIN;
          else                                 w_next = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        if (r_backoffCnt == CW'(RETRY_CYCLES - 1)) w_next = S_META;
      end
      S_DATA: begin
        s_axis_data_tready   = m_axis_tcp_tx_tready;
        m_axis_tcp_tx_tvalid = s_axis_data_tvalid;
        m_axis_tcp_tx_tdata  = s_axis_data_tdata;
        m_axis_tcp_tx_tkeep  = w_lastBeat ? w_lastKeep : '1;
        m_axis_tcp_tx_tlast  = w_lastBeat;
        if (s_axis_data_tvalid && m_axis_tcp_tx_tready && w_lastBeat)
          w_next = (r_rem == r_chunk) ? S_CPL : S_META;
      end
      S_DRAIN: begin
        s_axis_data_tready = 1'b1;
        if (s_axis_data_tvalid && w_lastBeat) w_next = S_CPL;
      end
      S_CPL: begin
        m_cpl_valid = 1'b1;
        m_cpl_data  = {r_abort, r_sent, r_sid};
        if (m_cpl_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: the beat counter is shared between payload streaming and draining
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_sid        <= '0;
      r_rem        <= '0;
      r_sent       <= '0;
      r_chunk      <= '0;
      r_beats      <= '0;
      r_beatCnt    <= '0;
      r_retries    <= '0;
      r_backoffCnt <= '0;
      r_abort      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_cmd_valid) begin
            r_sid     <= s_cmd_data[15:0];
            r_rem     <= s_cmd_data[31:16];
            r_sent    <= '0;
            r_retries <= '0;
            r_abort   <= 1'b0;
          end
        end
        S_META: begin
          if (m_tcp_tx_meta_ready) r_chunk <= w_chunk;
        end
        S_STAT: begin
          if (s_tcp_tx_stat_valid) begin
            r_beatCnt <= '0;
            if (!w_statErr) begin
              r_beats   <= w_chunkBeats;
              r_retries <= '0;
            end else begin
              r_beats      <= w_remBeats;
              r_retries    <= w_retryNext;
              r_backoffCnt <= '0;
            end
          end
        end
        S_BACKOFF: r_backoffCnt <= r_backoffCnt + CW'(1);
        S_DATA: begin
          if (s_axis_data_tvalid && m_axis_tcp_tx_tready) begin
            r_beatCnt <= r_beatCnt + 16'd1;
            if (w_lastBeat) begin
              r_rem  <= r_rem - r_chunk;
              r_sent <= r_sent + r_chunk;
            end
          end
        end
        S_DRAIN: begin
          if (s_axis_data_tvalid) begin
            r_beatCnt <= r_beatCnt + 16'd1;
            if (w_lastBeat) r_abort <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_sender.sv
// Directed self-checking bench for tcp_tx_sender: single and multi-packet sends,
// retry/backoff timing, abort with drain, back-pressure, and mid-transfer reset.
module tb_tcp_tx_sender;

  logic         aclk = 1'b0;
  logic         areset;
  logic         s_cmd_valid;
  logic         s_cmd_ready;
  logic [31:0]  s_cmd_data;
  logic         m_tcp_tx_meta_valid;
  logic         m_tcp_tx_meta_ready;
  logic [31:0]  m_tcp_tx_meta_data;
  logic         s_tcp_tx_stat_valid;
  logic         s_tcp_tx_stat_ready;
  logic [63:0]  s_tcp_tx_stat_data;
  logic         s_axis_data_tvalid;
  logic         s_axis_data_tready;
  logic [511:0] s_axis_data_tdata;
  logic         m_axis_tcp_tx_tvalid;
  logic         m_axis_tcp_tx_tready;
  logic [511:0] m_axis_tcp_tx_tdata;
  logic [63:0]  m_axis_tcp_tx_tkeep;
  logic         m_axis_tcp_tx_tlast;
  logic         m_cpl_valid;
  logic         m_cpl_ready;
  logic [32:0]  m_cpl_data;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  tcp_tx_sender dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_cmd_valid          (s_cmd_valid),
    .s_cmd_ready          (s_cmd_ready),
    .s_cmd_data           (s_cmd_data),
    .m_tcp_tx_meta_valid  (m_tcp_tx_meta_valid),
    .m_tcp_tx_meta_ready  (m_tcp_tx_meta_ready),
    .m_tcp_tx_meta_data   (m_tcp_tx_meta_data),
    .s_tcp_tx_stat_valid  (s_tcp_tx_stat_valid),
    .s_tcp_tx_stat_ready  (s_tcp_tx_stat_ready),
    .s_tcp_tx_stat_data   (s_tcp_tx_stat_data),
    .s_axis_data_tvalid   (s_axis_data_tvalid),
    .s_axis_data_tready   (s_axis_data_tready),
    .s_axis_data_tdata    (s_axis_data_tdata),
    .m_axis_tcp_tx_tvalid (m_axis_tcp_tx_tvalid),
    .m_axis_tcp_tx_tready (m_axis_tcp_tx_tready),
    .m_axis_tcp_tx_tdata  (m_axis_tcp_tx_tdata),
    .m_axis_tcp_tx_tkeep  (m_axis_tcp_tx_tkeep),
    .m_axis_tcp_tx_tlast  (m_axis_tcp_tx_tlast),
    .m_cpl_valid          (m_cpl_valid),
    .m_cpl_ready          (m_cpl_ready),
    .m_cpl_data           (m_cpl_data)
  );

  always #5 aclk = ~aclk;

  // Wide comparison; narrower fields are zero-extended by the caller
  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  function automatic logic [511:0] pat(input int n);
    return {16{32'(n) ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [63:0] expKeep(input int chunk, input int b, input int beats);
    int r;
    r = chunk % 64;
    if (b != beats - 1 || r == 0) return '1;
    return (64'd1 << r) - 64'd1;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [511:0] d, input logic rdy);
    s_axis_data_tvalid   = v;
    s_axis_data_tdata    = d;
    m_axis_tcp_tx_tready = rdy;
  endtask

  task automatic doReset();
    areset              = 1'b1;
    s_cmd_valid         = 1'b0;
    s_cmd_data          = '0;
    m_tcp_tx_meta_ready = 1'b0;
    s_tcp_tx_stat_valid = 1'b0;
    s_tcp_tx_stat_data  = '0;
    m_cpl_ready         = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    step();
    step();
    areset = 1'b0;
    #1;
    checkBit("rst_cmd_ready", s_cmd_ready, 1'b1);
    checkBit("rst_meta_valid", m_tcp_tx_meta_valid, 1'b0);
    checkBit("rst_stat_ready", s_tcp_tx_stat_ready, 1'b0);
    checkBit("rst_axis_tready", s_axis_data_tready, 1'b0);
    checkBit("rst_tx_tvalid", m_axis_tcp_tx_tvalid, 1'b0);
    checkBit("rst_cpl_valid", m_cpl_valid, 1'b0);
    checkOutput("rst_meta_data", 512'(m_tcp_tx_meta_data), 512'd0);
    checkOutput("rst_tkeep", 512'(m_axis_tcp_tx_tkeep), 512'd0);
    checkOutput("rst_cpl_data", 512'(m_cpl_data), 512'd0);
  endtask

  task automatic sendCmd(input logic [15:0] sid, input logic [15:0] len);
    s_cmd_valid = 1'b1;
    s_cmd_data  = {len, sid};
    #1;
    checkBit("cmd_ready", s_cmd_ready, 1'b1);
    step();
    s_cmd_valid = 1'b0;
    checkBit("meta_latency", m_tcp_tx_meta_valid, 1'b1);
    checkBit("cmd_ready_drop", s_cmd_ready, 1'b0);
  endtask

  task automatic doMeta(input logic [31:0] expData, output int waited);
    waited = 0;
    while (!m_tcp_tx_meta_valid && waited < 2000) begin
      step();
      waited++;
    end
    checkBit("meta_valid", m_tcp_tx_meta_valid, 1'b1);
    checkOutput("meta_data", 512'(m_tcp_tx_meta_data), 512'(expData));
    step();
    checkBit("meta_hold_valid", m_tcp_tx_meta_valid, 1'b1);
    checkOutput("meta_hold_data", 512'(m_tcp_tx_meta_data), 512'(expData));
    m_tcp_tx_meta_ready = 1'b1;
    step();
    m_tcp_tx_meta_ready = 1'b0;
    checkBit("stat_ready", s_tcp_tx_stat_ready, 1'b1);
    checkBit("meta_valid_off", m_tcp_tx_meta_valid, 1'b0);
  endtask

  task automatic doStat(input logic [1:0] err);
    s_tcp_tx_stat_valid = 1'b1;
    s_tcp_tx_stat_data  = {err, 30'd1000, 16'd0, 16'd0};
    step();
    s_tcp_tx_stat_valid = 1'b0;
  endtask

  task automatic doData(input int chunk, input int seed);
    int beats;
    beats = (chunk + 63) / 64;
    for (int b = 0; b < beats; b++) begin
      applyStimulus(1'b1, pat(seed + b), 1'b1);
      #1;
      checkBit("data_tvalid", m_axis_tcp_tx_tvalid, 1'b1);
      checkOutput("data_tdata", m_axis_tcp_tx_tdata, pat(seed + b));
      checkOutput("data_tkeep", 512'(m_axis_tcp_tx_tkeep), 512'(expKeep(chunk, b, beats)));
      checkBit("data_tlast", m_axis_tcp_tx_tlast, b == beats - 1);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic doCpl(input logic [32:0] expData);
    int n;
    n = 0;
    while (!m_cpl_valid && n < 2000) begin
      step();
      n++;
    end
    checkBit("cpl_valid", m_cpl_valid, 1'b1);
    checkOutput("cpl_data", 512'(m_cpl_data), 512'(expData));
    m_cpl_ready = 1'b1;
    step();
    m_cpl_ready = 1'b0;
    checkBit("cpl_valid_off", m_cpl_valid, 1'b0);
    checkBit("cmd_ready_after_cpl", s_cmd_ready, 1'b1);
  endtask

  initial begin
    int waited;
    int outIdx;
    int srcIdx;
    int cyc;
    logic done;

    $display("[TB] starting tcp_tx_sender bench");
    doReset();

    // Single short packet: 100 bytes -> 2 beats, 36-byte tail
    sendCmd(16'h0005, 16'd100);
    doMeta({16'd100, 16'h0005}, waited);
    doStat(2'd0);
    doData(100, 0);
    doCpl({1'b0, 16'd100, 16'h0005});

    // Multi-packet split: 10000 = 4096 + 4096 + 1808
    sendCmd(16'h000A, 16'd10000);
    doMeta({16'd4096, 16'h000A}, waited);
    doStat(2'd0);
    doData(4096, 1000);
    doMeta({16'd4096, 16'h000A}, waited);
    doStat(2'd0);
    doData(4096, 2000);
    doMeta({16'd1808, 16'h000A}, waited);
    doStat(2'd0);
    doData(1808, 3000);
    doCpl({1'b0, 16'd10000, 16'h000A});

    // One stat error then OK: re-issue exactly 256 cycles after the error stat
    sendCmd(16'h0007, 16'd64);
    doMeta({16'd64, 16'h0007}, waited);
    doStat(2'd1);
    checkBit("backoff_no_meta", m_tcp_tx_meta_valid, 1'b0);
    doMeta({16'd64, 16'h0007}, waited);
    checkOutput("retry_delay", 512'(waited), 512'd256);
    doStat(2'd0);
    doData(64, 4000);
    doCpl({1'b0, 16'd64, 16'h0007});

    // Sixteen consecutive errors: abort, drain 4 beats without output
    sendCmd(16'h0009, 16'd200);
    for (int r = 0; r < 16; r++) begin
      doMeta({16'd200, 16'h0009}, waited);
      doStat(2'd2);
    end
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, pat(5000 + b), 1'b0);
      #1;
      checkBit("drain_tready", s_axis_data_tready, 1'b1);
      checkBit("drain_no_tvalid", m_axis_tcp_tx_tvalid, 1'b0);
      checkBit("drain_no_meta", m_tcp_tx_meta_valid, 1'b0);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0);
    doCpl({1'b1, 16'd0, 16'h0009});

    // Random back-pressure on a full 4096-byte packet
    sendCmd(16'h0011, 16'd4096);
    doMeta({16'd4096, 16'h0011}, waited);
    doStat(2'd0);
    outIdx = 0;
    srcIdx = 0;
    cyc    = 0;
    while (outIdx < 64 && cyc < 2000) begin
      applyStimulus(1'($urandom_range(0, 1)), pat(6000 + srcIdx), 1'($urandom_range(0, 1)));
      #1;
      checkBit("bp_ready_pass", s_axis_data_tready, m_axis_tcp_tx_tready);
      if (m_axis_tcp_tx_tvalid && m_axis_tcp_tx_tready) begin
        checkOutput("bp_tdata", m_axis_tcp_tx_tdata, pat(6000 + outIdx));
        checkBit("bp_tlast", m_axis_tcp_tx_tlast, outIdx == 63);
        outIdx++;
      end
      if (s_axis_data_tvalid && s_axis_data_tready) srcIdx++;
      step();
      cyc++;
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("bp_out_beats", 512'(outIdx), 512'd64);
    checkOutput("bp_in_beats", 512'(srcIdx), 512'd64);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      m_cpl_ready = (i == 19) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      checkBit("bp_cpl_valid", m_cpl_valid, 1'b1);
      checkOutput("bp_cpl_data", 512'(m_cpl_data), 512'({1'b0, 16'd4096, 16'h0011}));
      done = m_cpl_ready;
      step();
    end
    m_cpl_ready = 1'b0;
    checkBit("bp_cmd_ready", s_cmd_ready, 1'b1);

    // Reset asserted while beat 10 is on the bus
    sendCmd(16'h0021, 16'd1000);
    doMeta({16'd1000, 16'h0021}, waited);
    doStat(2'd0);
    for (int b = 0; b < 10; b++) begin
      applyStimulus(1'b1, pat(7000 + b), 1'b1);
      step();
    end
    applyStimulus(1'b1, pat(7010), 1'b1);
    #1;
    checkBit("pre_rst_tvalid", m_axis_tcp_tx_tvalid, 1'b1);
    checkBit("pre_rst_tlast", m_axis_tcp_tx_tlast, 1'b0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    checkBit("mid_rst_tvalid", m_axis_tcp_tx_tvalid, 1'b0);
    checkBit("mid_rst_meta", m_tcp_tx_meta_valid, 1'b0);
    checkBit("mid_rst_stat", s_tcp_tx_stat_ready, 1'b0);
    checkBit("mid_rst_cpl", m_cpl_valid, 1'b0);
    checkBit("mid_rst_cmd_ready", s_cmd_ready, 1'b1);
    step();
    checkBit("mid_rst_no_cpl", m_cpl_valid, 1'b0);
    sendCmd(16'h0022, 16'd64);
    doMeta({16'd64, 16'h0022}, waited);
    doStat(2'd0);
    doData(64, 8000);
    doCpl({1'b0, 16'd64, 16'h0022});

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
